// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle for alu_op_sequencer.
// The master issues commands and consumes responses; the slave is the sequencer.
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_cin;
  logic [1:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around a 32-bit combinational ALU with per-class settle windows.
// Optional feature macro: ALU_SEQ_DIVZERO_EN (divide-by-zero intercept, latency 1).
module alu_op_sequencer #(
    parameter int SETTLE_ADD    = 1,
    parameter int SETTLE_MULDIV = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic                alu_cin,
    output logic [1:0]          alu_op,
    input  logic [31:0]         alu_f,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] N_ADD = 4'(SETTLE_ADD);
    localparam logic [3:0] N_MD  = 4'(SETTLE_MULDIV);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        dz_q;
    logic        dz_cmd;
    logic [3:0]  n_load;
    logic        accept, capture, rsp_hs;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        rsp_valid_q;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and payload is held while valid && !ready.
    assign bus.cmd_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign rsp_hs        = rsp_valid_q && bus.rsp_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

`ifdef ALU_SEQ_DIVZERO_EN
    assign dz_cmd = (bus.cmd_op == 2'b11) && (bus.cmd_b == 32'd0);
`else
    assign dz_cmd = 1'b0;
`endif

    // An intercepted divide-by-zero spends a single settle cycle, giving latency 1.
    always_comb begin
        n_load = bus.cmd_op[1] ? N_MD : N_ADD;
        if (dz_cmd) n_load = 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:   if (accept) state_nxt = SETTLE;
            SETTLE: if (cnt == 4'd1) begin
                        capture   = 1'b1;
                        state_nxt = RESP;
                    end
            RESP:   if (rsp_hs) state_nxt = accept ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_cin     <= 1'b0;
            alu_op      <= 2'b00;
            cnt         <= 4'd0;
            dz_q        <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= bus.cmd_a;
                alu_b   <= bus.cmd_b;
                alu_cin <= bus.cmd_cin;
                alu_op  <= bus.cmd_op;
                cnt     <= n_load;
                dz_q    <= dz_cmd;
            end else if (state == SETTLE) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                rsp_data_q  <= dz_q ? 32'hFFFF_FFFF : alu_f;
                rsp_err_q   <= dz_q;
                rsp_valid_q <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
